// File: rtl/pito_pkg.sv
// Shared types and default sizes for the pito next-PC interrupt scheduler.
package pito_pkg;

    localparam int IRQ_Q_DEPTH    = 4;   // pending-event FIFO entries per hart
    localparam int IRQ_NEST_DEPTH = 2;   // return-PC stack entries per hart
    localparam int PITO_XLEN      = 32;

    // Per-hart handler state: IDLE while nest count is 0, ISR otherwise.
    typedef enum logic {
        IRQ_IDLE = 1'b0,
        IRQ_ISR  = 1'b1
    } irq_sched_state_t;

    // Handler-address event as produced by the CSR unit.
    typedef struct packed {
        logic                 valid;
        logic [PITO_XLEN-1:0] data;
    } irq_evt_t;

endpackage

// File: rtl/rv32_irq_sched_if.sv
// CSR-side event bus of the interrupt scheduler: one strobe/address/ready per hart.
interface rv32_irq_sched_if #(
    parameter int NUM_HARTS = 8,
    parameter int PC_W      = 32
);
    logic [NUM_HARTS-1:0]           irq_valid_i;
    logic [NUM_HARTS-1:0][PC_W-1:0] irq_data_i;
    logic [NUM_HARTS-1:0]           irq_ready_o;

    // CSR unit drives events
    modport master (output irq_valid_i, output irq_data_i, input irq_ready_o);
    // scheduler consumes them
    modport slave  (input irq_valid_i, input irq_data_i, output irq_ready_o);
endinterface

// File: rtl/rv32_irq_fifo.sv
// Single-hart pending-event FIFO. Push while full and pop while empty are ignored.
// Entry storage is not reset; only pointers and count are.
module rv32_irq_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count;
    logic          push_ok, pop_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    // Pointer/count bookkeeping; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry write; contents survive reset on purpose.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/rv32_irq_sched.sv
// Per-hart interrupt scheduler for the barrel next-PC stage.
// Buffers CSR handler events per hart, redirects the hart in the stage into a
// handler, saves its resume PC and restores it on MRET.
// Build option: PITO_IRQ_NEST_EN enables nested handlers up to NEST_DEPTH;
// without it each hart holds one return PC and handlers do not nest.
module rv32_irq_sched
    import pito_pkg::*;
#(
    parameter int NUM_HARTS   = 8,
    parameter int IRQ_Q_DEPTH = pito_pkg::IRQ_Q_DEPTH,
    parameter int NEST_DEPTH  = IRQ_NEST_DEPTH,
    parameter int PC_W        = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    rv32_irq_sched_if.slave              csr,
    input  logic [$clog2(NUM_HARTS)-1:0] hart_id_i,
    input  logic                         slot_valid_i,
    input  logic                         is_mret_i,
    input  logic [PC_W-1:0]              ret_pc_i,
    output logic                         redirect_o,
    output logic [PC_W-1:0]              redirect_pc_o,
    output logic [NUM_HARTS-1:0]         pending_o,
    output logic [NUM_HARTS-1:0]         in_isr_o,
    output logic [NUM_HARTS-1:0]         overflow_o
);

`ifdef PITO_IRQ_NEST_EN
    localparam int NEST_LIM = NEST_DEPTH;
`else
    // Nesting disabled: NEST_DEPTH has no effect, one return PC per hart.
    localparam int NEST_LIM = 1 + 0 * NEST_DEPTH;
`endif
    localparam int NW = $clog2(NEST_LIM + 1);

    logic [NUM_HARTS-1:0]           full, empty;
    logic [NUM_HARTS-1:0]           take, mret_pop, can_nest;
    logic [NUM_HARTS-1:0][PC_W-1:0] head, ret_top;

    assign csr.irq_ready_o = ~full;
    assign pending_o       = ~empty;

    // Redirect decision for the hart in the stage: MRET first, then take.
    always_comb begin
        redirect_o    = 1'b0;
        redirect_pc_o = '0;
        take          = '0;
        mret_pop      = '0;
        if (slot_valid_i) begin
            if (is_mret_i) begin
                // MRET on an idle hart falls through to normal next-PC.
                if (in_isr_o[hart_id_i]) begin
                    redirect_o          = 1'b1;
                    redirect_pc_o       = ret_top[hart_id_i];
                    mret_pop[hart_id_i] = 1'b1;
                end
            end else if (pending_o[hart_id_i] && can_nest[hart_id_i]) begin
                redirect_o      = 1'b1;
                redirect_pc_o   = head[hart_id_i];
                take[hart_id_i] = 1'b1;
            end
        end
    end

    for (genvar h = 0; h < NUM_HARTS; h++) begin : g_hart
        irq_sched_state_t state_q, state_d;
        logic [NW-1:0]    nest_q, nest_d;
        logic [PC_W-1:0]  ret_stk [NEST_LIM];
        logic [PC_W-1:0]  ret_top_h;

        rv32_irq_fifo #(
            .DEPTH (IRQ_Q_DEPTH),
            .W     (PC_W)
        ) u_fifo (
            .clk       (clk),
            .rst_n     (rst_n),
            .push      (csr.irq_valid_i[h]),
            .push_data (csr.irq_data_i[h]),
            .pop       (take[h]),
            .full      (full[h]),
            .empty     (empty[h]),
            .head      (head[h])
        );

        assign in_isr_o[h] = (state_q == IRQ_ISR);
        assign can_nest[h] = (nest_q < NW'(NEST_LIM));
        assign ret_top[h]  = ret_top_h;

        // Sticky drop flag: an event arrived while this hart's FIFO was full.
        always_ff @(posedge clk) begin
            if (!rst_n)                             overflow_o[h] <= 1'b0;
            else if (csr.irq_valid_i[h] && full[h]) overflow_o[h] <= 1'b1;
        end

        // Handler state and nest count register.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                state_q <= IRQ_IDLE;
                nest_q  <= '0;
            end else begin
                state_q <= state_d;
                nest_q  <= nest_d;
            end
        end

        // Next handler state: enter on take, leave on the last MRET.
        always_comb begin
            state_d = state_q;
            nest_d  = nest_q;
            case (state_q)
                IRQ_IDLE: begin
                    if (take[h]) begin
                        state_d = IRQ_ISR;
                        nest_d  = nest_q + NW'(1);
                    end
                end
                IRQ_ISR: begin
                    if (mret_pop[h]) begin
                        nest_d = nest_q - NW'(1);
                        if (nest_q == NW'(1)) state_d = IRQ_IDLE;
                    end else if (take[h]) begin
                        nest_d = nest_q + NW'(1);
                    end
                end
                default: begin
                    state_d = IRQ_IDLE;
                    nest_d  = '0;
                end
            endcase
        end

        // Return-PC stack write at the current depth; storage is not reset.
        always_ff @(posedge clk) begin
            for (int e = 0; e < NEST_LIM; e++) begin
                if (take[h] && nest_q == NW'(e)) ret_stk[e] <= ret_pc_i;
            end
        end

        // Top of the return stack (entry nest-1).
        always_comb begin
            ret_top_h = '0;
            for (int e = 0; e < NEST_LIM; e++) begin
                if (nest_q == NW'(e + 1)) ret_top_h = ret_stk[e];
            end
        end
    end

endmodule

// File: tb/tb_rv32_irq_sched.sv
// Directed bench for rv32_irq_sched (default 8 harts, depth 4, 32-bit PC).
module tb_rv32_irq_sched;
    import pito_pkg::*;

    localparam int NH = 8;
    localparam int PW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [2:0]    hart_id_i;
    logic          slot_valid_i, is_mret_i;
    logic [PW-1:0] ret_pc_i;
    logic          redirect_o;
    logic [PW-1:0] redirect_pc_o;
    logic [NH-1:0] pending_o, in_isr_o, overflow_o;

    int checks = 0;
    int errors = 0;

    rv32_irq_sched_if #(.NUM_HARTS(NH), .PC_W(PW)) bus ();

    rv32_irq_sched #(.NUM_HARTS(NH), .IRQ_Q_DEPTH(4), .NEST_DEPTH(2), .PC_W(PW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .csr           (bus),
        .hart_id_i     (hart_id_i),
        .slot_valid_i  (slot_valid_i),
        .is_mret_i     (is_mret_i),
        .ret_pc_i      (ret_pc_i),
        .redirect_o    (redirect_o),
        .redirect_pc_o (redirect_pc_o),
        .pending_o     (pending_o),
        .in_isr_o      (in_isr_o),
        .overflow_o    (overflow_o)
    );

    always #5 clk = ~clk;

    task automatic clr();
        bus.irq_valid_i = '0;
        bus.irq_data_i  = '0;
        slot_valid_i    = 1'b0;
        is_mret_i       = 1'b0;
        hart_id_i       = '0;
        ret_pc_i        = '0;
    endtask

    // Advance one clock; outputs are then stable 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        clr();
        #1;
    endtask

    task automatic push_evt(input int h, input logic [PW-1:0] addr);
        irq_evt_t ev;
        ev.valid = 1'b1;
        ev.data  = addr;
        bus.irq_valid_i[h] = ev.valid;
        bus.irq_data_i[h]  = ev.data;
        #1;
    endtask

    task automatic slot(input int h, input logic mret, input logic [PW-1:0] rp);
        slot_valid_i = 1'b1;
        hart_id_i    = h[2:0];
        is_mret_i    = mret;
        ret_pc_i     = rp;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clr();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        checks++; if (bus.irq_ready_o !== 8'hFF) begin errors++; $display("FAIL rst_ready got %h exp ff", bus.irq_ready_o); end
        checks++; if (pending_o !== 8'h00) begin errors++; $display("FAIL rst_pending got %h exp 00", pending_o); end
        checks++; if (in_isr_o !== 8'h00) begin errors++; $display("FAIL rst_in_isr got %h exp 00", in_isr_o); end
        checks++; if (overflow_o !== 8'h00) begin errors++; $display("FAIL rst_overflow got %h exp 00", overflow_o); end
        slot(0, 1'b0, 32'h0);
        checks++; if (redirect_o !== 1'b0) begin errors++; $display("FAIL rst_redirect got %b exp 0", redirect_o); end
        tick();
    endtask

    task automatic test_take_mret();
        // Event and a hart-2 slot in the same cycle: no bypass.
        push_evt(2, 32'h100);
        slot(2, 1'b0, 32'h3c);
        checks++; if (redirect_o !== 1'b0) begin errors++; $display("FAIL nobypass got %b exp 0", redirect_o); end
        tick();
        slot(2, 1'b0, 32'h40);
        checks++; if ({redirect_o, redirect_pc_o} !== {1'b1, 32'h100}) begin errors++; $display("FAIL take2 got %b/%h exp 1/100", redirect_o, redirect_pc_o); end
        tick();
        checks++; if (in_isr_o[2] !== 1'b1 || pending_o[2] !== 1'b0) begin errors++; $display("FAIL isr2 got isr %b pend %b exp 1/0", in_isr_o[2], pending_o[2]); end
        slot(2, 1'b1, 32'h0);
        checks++; if ({redirect_o, redirect_pc_o} !== {1'b1, 32'h40}) begin errors++; $display("FAIL mret2 got %b/%h exp 1/40", redirect_o, redirect_pc_o); end
        tick();
        checks++; if (in_isr_o[2] !== 1'b0) begin errors++; $display("FAIL mret2_isr got %b exp 0", in_isr_o[2]); end
        slot(3, 1'b1, 32'h0);
        checks++; if (redirect_o !== 1'b0) begin errors++; $display("FAIL mret_idle3 got %b exp 0", redirect_o); end
        tick();
        checks++; if (in_isr_o !== 8'h00) begin errors++; $display("FAIL mret_idle3_isr got %h exp 00", in_isr_o); end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 5; i++) begin
            push_evt(0, 32'hA0 + 32'(4 * i));
            tick();
            if (i == 3) begin
                checks++; if (bus.irq_ready_o[0] !== 1'b0 || overflow_o[0] !== 1'b0) begin errors++; $display("FAIL ovf_full got rdy %b ovf %b exp 0/0", bus.irq_ready_o[0], overflow_o[0]); end
            end
        end
        checks++; if (overflow_o[0] !== 1'b1 || bus.irq_ready_o[0] !== 1'b0) begin errors++; $display("FAIL ovf_drop got ovf %b rdy %b exp 1/0", overflow_o[0], bus.irq_ready_o[0]); end
        for (int i = 0; i < 4; i++) begin
            slot(0, 1'b0, 32'h1000 + 32'(i));
            checks++; if ({redirect_o, redirect_pc_o} !== {1'b1, 32'hA0 + 32'(4 * i)}) begin errors++; $display("FAIL ovf_take%0d got %b/%h exp 1/%h", i, redirect_o, redirect_pc_o, 32'hA0 + 32'(4 * i)); end
            tick();
            slot(0, 1'b1, 32'h0);
            checks++; if ({redirect_o, redirect_pc_o} !== {1'b1, 32'h1000 + 32'(i)}) begin errors++; $display("FAIL ovf_mret%0d got %b/%h exp 1/%h", i, redirect_o, redirect_pc_o, 32'h1000 + 32'(i)); end
            tick();
        end
        checks++; if (pending_o[0] !== 1'b0 || overflow_o[0] !== 1'b1) begin errors++; $display("FAIL ovf_end got pend %b ovf %b exp 0/1", pending_o[0], overflow_o[0]); end
    endtask

    task automatic test_full_push_take();
        for (int i = 0; i < 4; i++) begin
            push_evt(1, 32'hC0 + 32'(4 * i));
            tick();
        end
        // Full: simultaneous push is dropped, take returns oldest.
        push_evt(1, 32'hD0);
        slot(1, 1'b0, 32'h2000);
        checks++; if ({redirect_o, redirect_pc_o} !== {1'b1, 32'hC0}) begin errors++; $display("FAIL full_take got %b/%h exp 1/c0", redirect_o, redirect_pc_o); end
        tick();
        checks++; if (overflow_o[1] !== 1'b1) begin errors++; $display("FAIL full_ovf got %b exp 1", overflow_o[1]); end
        slot(1, 1'b1, 32'h0);
        checks++; if ({redirect_o, redirect_pc_o} !== {1'b1, 32'h2000}) begin errors++; $display("FAIL full_mret got %b/%h exp 1/2000", redirect_o, redirect_pc_o); end
        tick();
        // Three entries: push+take keeps count at 3.
        push_evt(1, 32'hE0);
        slot(1, 1'b0, 32'h2100);
        checks++; if ({redirect_o, redirect_pc_o} !== {1'b1, 32'hC4}) begin errors++; $display("FAIL pt_take got %b/%h exp 1/c4", redirect_o, redirect_pc_o); end
        tick();
        checks++; if (bus.irq_ready_o[1] !== 1'b1 || pending_o[1] !== 1'b1) begin errors++; $display("FAIL pt_cnt got rdy %b pend %b exp 1/1", bus.irq_ready_o[1], pending_o[1]); end
        slot(1, 1'b1, 32'h0);
        checks++; if ({redirect_o, redirect_pc_o} !== {1'b1, 32'h2100}) begin errors++; $display("FAIL pt_mret got %b/%h exp 1/2100", redirect_o, redirect_pc_o); end
        tick();
        for (int i = 0; i < 3; i++) begin
            logic [PW-1:0] exp_pc;
            exp_pc = (i == 0) ? 32'hC8 : (i == 1) ? 32'hCC : 32'hE0;
            slot(1, 1'b0, 32'h2200);
            checks++; if ({redirect_o, redirect_pc_o} !== {1'b1, exp_pc}) begin errors++; $display("FAIL drain%0d got %b/%h exp 1/%h", i, redirect_o, redirect_pc_o, exp_pc); end
            tick();
            slot(1, 1'b1, 32'h0);
            tick();
        end
        checks++; if (pending_o[1] !== 1'b0 || in_isr_o[1] !== 1'b0) begin errors++; $display("FAIL drain_end got pend %b isr %b exp 0/0", pending_o[1], in_isr_o[1]); end
    endtask

`ifndef PITO_IRQ_NEST_EN
    task automatic test_defer();
        push_evt(4, 32'h300);
        tick();
        slot(4, 1'b0, 32'h50);
        checks++; if ({redirect_o, redirect_pc_o} !== {1'b1, 32'h300}) begin errors++; $display("FAIL def_take got %b/%h exp 1/300", redirect_o, redirect_pc_o); end
        tick();
        push_evt(4, 32'h200);
        tick();
        slot(4, 1'b0, 32'h54);
        checks++; if ({redirect_o, redirect_pc_o} !== {1'b0, 32'h0}) begin errors++; $display("FAIL def_hold got %b/%h exp 0/0", redirect_o, redirect_pc_o); end
        tick();
        checks++; if (pending_o[4] !== 1'b1 || in_isr_o[4] !== 1'b1) begin errors++; $display("FAIL def_state got pend %b isr %b exp 1/1", pending_o[4], in_isr_o[4]); end
        slot(4, 1'b1, 32'h0);
        checks++; if ({redirect_o, redirect_pc_o} !== {1'b1, 32'h50}) begin errors++; $display("FAIL def_mret got %b/%h exp 1/50", redirect_o, redirect_pc_o); end
        tick();
        slot(4, 1'b0, 32'h58);
        checks++; if ({redirect_o, redirect_pc_o} !== {1'b1, 32'h200}) begin errors++; $display("FAIL def_take2 got %b/%h exp 1/200", redirect_o, redirect_pc_o); end
        tick();
        slot(4, 1'b1, 32'h0);
        checks++; if ({redirect_o, redirect_pc_o} !== {1'b1, 32'h58}) begin errors++; $display("FAIL def_mret2 got %b/%h exp 1/58", redirect_o, redirect_pc_o); end
        tick();
    endtask
`else
    task automatic test_nest();
        push_evt(5, 32'h400); tick();
        push_evt(5, 32'h500); tick();
        push_evt(5, 32'h600); tick();
        slot(5, 1'b0, 32'h10);
        checks++; if ({redirect_o, redirect_pc_o} !== {1'b1, 32'h400}) begin errors++; $display("FAIL nest_t1 got %b/%h exp 1/400", redirect_o, redirect_pc_o); end
        tick();
        slot(5, 1'b0, 32'h20);
        checks++; if ({redirect_o, redirect_pc_o} !== {1'b1, 32'h500}) begin errors++; $display("FAIL nest_t2 got %b/%h exp 1/500", redirect_o, redirect_pc_o); end
        tick();
        slot(5, 1'b0, 32'h30);
        checks++; if ({redirect_o, redirect_pc_o} !== {1'b0, 32'h0}) begin errors++; $display("FAIL nest_defer got %b/%h exp 0/0", redirect_o, redirect_pc_o); end
        tick();
        checks++; if (pending_o[5] !== 1'b1) begin errors++; $display("FAIL nest_pend got %b exp 1", pending_o[5]); end
        slot(5, 1'b1, 32'h0);
        checks++; if ({redirect_o, redirect_pc_o} !== {1'b1, 32'h20}) begin errors++; $display("FAIL nest_m1 got %b/%h exp 1/20", redirect_o, redirect_pc_o); end
        tick();
        slot(5, 1'b1, 32'h0);
        checks++; if ({redirect_o, redirect_pc_o} !== {1'b1, 32'h10}) begin errors++; $display("FAIL nest_m2 got %b/%h exp 1/10", redirect_o, redirect_pc_o); end
        tick();
        checks++; if (in_isr_o[5] !== 1'b0) begin errors++; $display("FAIL nest_idle got %b exp 0", in_isr_o[5]); end
        slot(5, 1'b0, 32'h40);
        checks++; if ({redirect_o, redirect_pc_o} !== {1'b1, 32'h600}) begin errors++; $display("FAIL nest_t3 got %b/%h exp 1/600", redirect_o, redirect_pc_o); end
        tick();
        slot(5, 1'b1, 32'h0);
        checks++; if ({redirect_o, redirect_pc_o} !== {1'b1, 32'h40}) begin errors++; $display("FAIL nest_m3 got %b/%h exp 1/40", redirect_o, redirect_pc_o); end
        tick();
    endtask
`endif

    task automatic test_back_to_back();
        for (int h = 0; h < NH; h++) begin
            bus.irq_valid_i[h] = 1'b1;
            bus.irq_data_i[h]  = 32'h800 + 32'(16 * h);
        end
        tick();
        checks++; if (pending_o !== 8'hFF) begin errors++; $display("FAIL b2b_pend got %h exp ff", pending_o); end
        for (int h = 0; h < NH; h++) begin
            slot(h, 1'b0, 32'h900 + 32'(h));
            checks++; if ({redirect_o, redirect_pc_o} !== {1'b1, 32'h800 + 32'(16 * h)}) begin errors++; $display("FAIL b2b_take%0d got %b/%h exp 1/%h", h, redirect_o, redirect_pc_o, 32'h800 + 32'(16 * h)); end
            tick();
        end
        checks++; if (in_isr_o !== 8'hFF || pending_o !== 8'h00) begin errors++; $display("FAIL b2b_isr got isr %h pend %h exp ff/00", in_isr_o, pending_o); end
        for (int h = NH - 1; h >= 0; h--) begin
            slot(h, 1'b1, 32'h0);
            checks++; if ({redirect_o, redirect_pc_o} !== {1'b1, 32'h900 + 32'(h)}) begin errors++; $display("FAIL b2b_mret%0d got %b/%h exp 1/%h", h, redirect_o, redirect_pc_o, 32'h900 + 32'(h)); end
            tick();
        end
        checks++; if (in_isr_o !== 8'h00) begin errors++; $display("FAIL b2b_end got %h exp 00", in_isr_o); end
    endtask

    task automatic test_reset_mid();
        push_evt(6, 32'h700); tick();
        push_evt(6, 32'h704); tick();
        slot(6, 1'b0, 32'h60);
        checks++; if ({redirect_o, redirect_pc_o} !== {1'b1, 32'h700}) begin errors++; $display("FAIL rmid_take got %b/%h exp 1/700", redirect_o, redirect_pc_o); end
        tick();
        checks++; if (in_isr_o[6] !== 1'b1 || pending_o[6] !== 1'b1) begin errors++; $display("FAIL rmid_pre got isr %b pend %b exp 1/1", in_isr_o[6], pending_o[6]); end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        checks++; if (in_isr_o !== 8'h00 || pending_o !== 8'h00 || overflow_o !== 8'h00) begin errors++; $display("FAIL rmid_clr got isr %h pend %h ovf %h exp 00", in_isr_o, pending_o, overflow_o); end
        slot(6, 1'b1, 32'h0);
        checks++; if ({redirect_o, redirect_pc_o} !== {1'b0, 32'h0}) begin errors++; $display("FAIL rmid_mret got %b/%h exp 0/0", redirect_o, redirect_pc_o); end
        tick();
    endtask

    initial begin
        test_reset();
        test_take_mret();
        test_overflow();
        test_full_push_take();
`ifndef PITO_IRQ_NEST_EN
        test_defer();
`else
        test_nest();
`endif
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
